// File: rtl/uart_tx_mmio_if.sv
// Bus bundle between the core's store/load path and the UART TX peripheral.
interface uart_tx_mmio_if;
  logic [3:0]  bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wen,
    output bus_ren,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wen,
    input  bus_ren,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a small FIFO that a
// serialiser drains onto the tx pin; STATUS exposes busy/full/empty/overflow.
module uart_tx_mmio #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_mmio_if.slave        bus,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [AW:0]     CountMax = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CountOne = (AW + 1)'(1);
  localparam logic [AW-1:0]   PtrOne   = AW'(1);

  localparam logic [3:0] AddrTxData = 4'h0;
  localparam logic [3:0] AddrStatus = 4'h4;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            fifo_empty, fifo_full;
  logic            wr_txdata, wr_status;
  logic            push, pop;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^bus.bus_wdata[31:8];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountMax);
  assign wr_txdata  = bus.bus_wen && (bus.bus_addr == AddrTxData);
  assign wr_status  = bus.bus_wen && (bus.bus_addr == AddrStatus);
  // Full is judged on the pre-edge count, so a same-cycle pop cannot make room.
  assign push       = wr_txdata && !fifo_full;
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign tx_busy    = (state_q != StIdle) || !fifo_empty;
  assign status     = {28'b0, overflow_q, fifo_empty, fifo_full, tx_busy};

  assign tx            = tx_q;
  assign bus.bus_rdata = rdata_q;

  // FIFO pointer/count, sticky overflow and read-data next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rdata_d    = rdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
    if (wr_txdata && fifo_full) overflow_d = 1'b1;
    if (wr_status)              overflow_d = 1'b0;
    if (bus.bus_ren) rdata_d = (bus.bus_addr == AddrStatus) ? status : 32'h0;
  end

  // Control/status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.bus_wdata[7:0];
  end

  // Serialiser FSM; tx is registered from the current state, so the line lags
  // the state by one cycle and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (!fifo_empty) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (baud_q == CntMax) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
          end else begin
            baud_q <= baud_q + CntOne;
          end
        end
        StData: begin
          tx_q <= shift_q[0];
          if (baud_q == CntMax) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= StStop;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + CntOne;
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (baud_q == CntMax) begin
            baud_q  <= '0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
